hamming_uart_rx: RTL
====================

HAMMING_UART_RX -- requirements
Module: hamming_uart_rx

Interface
REQ-001 SHALL have parameter CYCLES_PER_BIT, default 434: clk_50M cycles per bit period.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, legal range 5..11: payload bits per frame.
REQ-003 SHALL have port clk_50M, input, 1: single clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_data, output, DATA_WIDTH: decoded payload.
REQ-007 SHALL have port rx_valid, output, 1: rx_data and flags are valid.
REQ-008 SHALL have port rx_ready, input, 1: consumer accepts the word when rx_valid=1 and rx_ready=1.
REQ-009 SHALL have port err_corrected, output, 1: a single-bit error was corrected; qualified by rx_valid.
REQ-010 SHALL have port err_uncorrectable, output, 1: a double error was detected; qualified by rx_valid.
REQ-011 SHALL have port err_frame, output, 1: one-cycle pulse, stop bit was sampled low.
REQ-012 SHALL have port overrun, output, 1: one-cycle pulse, a completed frame was dropped.

Function
REQ-013 SHALL synchronise rx through two flops that reset to 1; all sampling uses the second flop.
REQ-014 SHALL use frame format: start(0), N=DATA_WIDTH+5 code bits sent LSB-first, stop(1).
REQ-015 SHALL map code bit i (0..N-2) to Hamming position i+1.
REQ-016 SHALL place parity at positions 1, 2, 4 and 8, and data bits ascending at the remaining positions, with data[0] at position 3.
REQ-017 SHALL make code bit N-1 the overall even parity over code bits 0..N-2.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP, DECODE and WAIT_HIGH; reset state is IDLE.
REQ-019 SHALL, in IDLE, go to START when the synchronised line is 0.
REQ-020 SHALL, in START, check the line at count (CYCLES_PER_BIT-1)/2: if 0, go to DATA with count 0; if 1, return to IDLE (glitch rejection).
REQ-021 SHALL, in DATA, sample at count CYCLES_PER_BIT-1 into code bit index 0..N-1, then go to STOP after index N-1.
REQ-022 SHALL, in STOP, sample at count CYCLES_PER_BIT-1: if 1, go to DECODE; if 0, pulse err_frame, discard the frame and go to WAIT_HIGH.
REQ-023 SHALL, in WAIT_HIGH, stay until the synchronised line is 1, then go to IDLE.
REQ-024 SHALL, in DECODE (one cycle), compute syndrome S (4 bits, XOR of positions of set bits) and overall check p.
REQ-025 SHALL decode S=0,p=0 as clean: no flags.
REQ-026 SHALL decode S=0,p=1 as an error in the overall parity bit: data unchanged, err_corrected=1.
REQ-027 SHALL decode S!=0,p=1 with S<=N-1 by flipping position S: err_corrected=1.
REQ-028 SHALL decode S!=0,p=1 with S>N-1 as uncorrectable.
REQ-029 SHALL decode S!=0,p=0 as uncorrectable.
REQ-030 SHALL, on uncorrectable, deliver data raw and set err_uncorrectable=1.
REQ-031 SHALL assert rx_valid exactly 1 cycle after DECODE, i.e. 2 cycles after the stop-bit sample; DECODE then returns to IDLE.
REQ-032 SHALL hold rx_valid, rx_data, err_corrected and err_uncorrectable stable until the handshake; rx_valid deasserts the cycle after the handshake.
REQ-033 SHALL, if DECODE completes while rx_valid=1 and rx_ready=0, drop the new frame, keep the held word, and pulse overrun.
REQ-034 SHALL treat a handshake in the same cycle as DECODE completion as freeing the slot: the new word is loaded with no overrun.
REQ-035 SHALL keep receiving subsequent frames regardless of rx_ready.

Reset
REQ-036 SHALL, on rst_n=0 at any time including mid-frame, immediately force: state IDLE, counters 0, synchroniser flops 1, rx_data 0, rx_valid 0, all flags 0.
REQ-037 SHALL wait after reset release for a full new start bit; no partial frame is completed.

Verification (DATA_WIDTH=8, CYCLES_PER_BIT=16, bench encoder)
REQ-038 SHALL verify: clean frame 0xA5, rx_ready=1 -> rx_data=0xA5 and rx_valid for 1 cycle, 2 cycles after the stop sample, no flags.
REQ-039 SHALL verify: 0xA5 with code bit 4 (position 5) inverted -> rx_data=0xA5, err_corrected=1; with the overall parity bit inverted -> 0xA5, err_corrected=1.
REQ-040 SHALL verify: 0xA5 with positions 3 and 6 inverted -> err_uncorrectable=1, rx_data = raw data bits.
REQ-041 SHALL verify: stop bit driven 0, line then held low 3 bit times -> err_frame pulse, no rx_valid; next clean 0x5A is received correctly.
REQ-042 SHALL verify: rx_ready=0, frames 0x3C then 0x5A -> rx_data stays 0x3C, overrun pulses once; raising rx_ready accepts 0x3C.
REQ-043 SHALL verify: rst_n pulsed low during data bit 6 -> all outputs 0 immediately; next frame 0x81 is received clean; a 3-cycle low glitch on idle rx produces no output.

Source files
------------

// File: rtl/hamming_uart_rx.sv
// hamming_uart_rx
//   UART receiver carrying a SECDED Hamming-coded payload.
//   Frame: start(0), DATA_WIDTH+5 code bits LSB-first, stop(1).
//   Code bit i is Hamming position i+1. Parity sits at positions 1,2,4,8 and
//   data fills the other positions in ascending order. The last code bit is the
//   overall even parity.
//
// Ports
//   clk_50M           : clock
//   rst_n             : asynchronous active-low reset
//   rx                : serial line (asynchronous, idle high)
//   rx_data           : decoded payload, held until the handshake
//   rx_valid          : rx_data and the err_* flags are valid
//   rx_ready          : consumer accepts the word while rx_valid=1
//   err_corrected     : a single-bit error was corrected (qualified by rx_valid)
//   err_uncorrectable : a double error was detected, so rx_data is raw (qualified by rx_valid)
//   err_frame         : one-cycle pulse when the stop bit is sampled low
//   overrun           : one-cycle pulse when a completed frame is dropped
module hamming_uart_rx #(
    parameter int CYCLES_PER_BIT = 434,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  clk_50M,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  err_corrected,
    output logic                  err_uncorrectable,
    output logic                  err_frame,
    output logic                  overrun
);
    localparam int N  = DATA_WIDTH + 5;
    localparam int CW = $clog2(CYCLES_PER_BIT + 1);
    localparam int IW = $clog2(N);
    localparam logic [CW-1:0] MID  = CW'((CYCLES_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [N-1:0]  ONE  = N'(1);

    // Hamming position that carries data bit j (skip the powers of two).
    function automatic int data_pos(input int j);
        int r;
        int k;
        r = 0;
        k = 0;
        for (int pos = 3; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (k == j) r = pos;
                k++;
            end
        end
        return r;
    endfunction

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE, WAIT_HIGH} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [N-1:0]    code;
    logic            rx_m, rx_s;
    logic            shift_en, frame_bad, dec_en;

    // Two-flop synchroniser. It resets to idle-high so that reset is never seen as a start bit.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            code  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            // LSB-first: after N shifts the first received bit lands in code[0].
            if (shift_en) code <= {rx_s, code[N-1:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_en  = 1'b0;
        frame_bad = 1'b0;
        dec_en    = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Re-check at mid start bit. Counting from 0 in DATA then samples mid-bit.
                if (cnt == MID) begin
                    cnt_nxt   = '0;
                    state_nxt = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_nxt  = '0;
                    shift_en = 1'b1;
                    if (idx == IW'(N - 1)) state_nxt = STOP;
                    else                   idx_nxt   = idx + 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = DECODE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DECODE: begin
                dec_en    = 1'b1;
                state_nxt = IDLE;
            end
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // SECDED decode of the captured code word.
    logic [3:0]            syn;
    logic                  par;
    logic [N-1:0]          fixed;
    logic                  corr, unc;
    logic [DATA_WIDTH-1:0] dec_data;

    always_comb begin
        syn = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (code[i]) syn = syn ^ 4'(i + 1);
        end
        par   = ^code;
        fixed = code;
        corr  = 1'b0;
        unc   = 1'b0;
        if (syn == 4'd0) begin
            corr = par;                             // error in the overall parity bit only
        end else if (par && (int'(syn) <= N - 1)) begin
            fixed = code ^ (ONE << (syn - 4'd1));   // flip position syn
            corr  = 1'b1;
        end else begin
            unc = 1'b1;                             // even error count, or syndrome off the end
        end
    end

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_dat
        localparam int P = data_pos(j);
        assign dec_data[j] = fixed[P-1];
    end

    // Single-entry output slot. A handshake in the DECODE cycle frees the slot.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_data           <= '0;
            rx_valid          <= 1'b0;
            err_corrected     <= 1'b0;
            err_uncorrectable <= 1'b0;
            err_frame         <= 1'b0;
            overrun           <= 1'b0;
        end else begin
            err_frame <= frame_bad;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (dec_en) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid          <= 1'b1;
                    rx_data           <= dec_data;
                    err_corrected     <= corr;
                    err_uncorrectable <= unc;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
endmodule
